pll_reset_sequencer: RTL and testbench

- Controls the ECP5 EHXPLLL wrapper (48 MHz in, 25.6 MHz out).
- Drives the PLL RST pin, qualifies the PLL LOCK output, and releases the system reset only after lock has been stable for a set time.
- Retries failed lock attempts and escalates to a sticky fault. Lock loss while running restarts the sequence.
- Runs on the free-running board reference clock (48 MHz), never on the PLL output.

---
 rtl/pll_reset_sequencer.sv | 166 ++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Brings up the ECP5 EHXPLLL and releases the downstream reset once lock is
// stable. It pulses the PLL RST pin, waits for lock with a timeout, requires a
// run of consecutive locked cycles, retries failed attempts and parks in a
// sticky FAULT when the retries run out. If lock is lost while running, the
// whole sequence starts again. Runs on the free-running board reference clock.
//
// Ports:
//   clock       board reference clock (48 MHz)
//   reset_n     synchronous active-low reset
//   pll_lock    raw PLL LOCK, asynchronous to clock
//   restart     single-cycle request to restart the sequence
//   pll_rst     EHXPLLL RST, active high
//   sys_rst_n   active-low downstream reset, straight from a flop
//   ready       high while in RUN
//   fault       sticky, high in FAULT
//   retries     failed attempts in the current sequence
//   lock_losses saturating count of lock drops seen in RUN
module pll_reset_sequencer #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 4800,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retries,
    output logic [7:0] lock_losses
);

    localparam int unsigned CNT_MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned CNT_MAX    = (CNT_MAX_AB > STABLE_CYCLES) ? CNT_MAX_AB : STABLE_CYCLES;
    localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_LIMIT = 2'(MAX_RETRIES);

    localparam logic [2:0] S_RESET_PLL = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABILIZE = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAULT     = 3'd4;

    logic             lock_m;
    logic             lock_s;
    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [1:0]       retries_nx;
    logic [7:0]       lock_losses_nx;
    logic             attempt_fail;

    // State, counters, synchronizer and registered outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            lock_m      <= 1'b0;
            lock_s      <= 1'b0;
            state       <= S_RESET_PLL;
            cnt         <= '0;
            retries     <= 2'd0;
            lock_losses <= 8'd0;
            pll_rst     <= 1'b1;
            sys_rst_n   <= 1'b0;
            ready       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            lock_m      <= pll_lock;
            lock_s      <= lock_m;
            state       <= state_nx;
            cnt         <= cnt_nx;
            retries     <= retries_nx;
            lock_losses <= lock_losses_nx;
            // Outputs are decoded from the next state so they change on the
            // same edge as the state and come straight out of flops.
            pll_rst     <= (state_nx == S_RESET_PLL) || (state_nx == S_FAULT);
            sys_rst_n   <= (state_nx == S_RUN);
            ready       <= (state_nx == S_RUN);
            fault       <= (state_nx == S_FAULT);
        end
    end

    // Next-state logic; restart overrides every failure or release decision
    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        retries_nx     = retries;
        lock_losses_nx = lock_losses;
        attempt_fail   = 1'b0;

        if (restart) begin
            state_nx   = S_RESET_PLL;
            cnt_nx     = '0;
            retries_nx = 2'd0;
        end else begin
            case (state)
                S_RESET_PLL: begin
                    if (cnt == RST_LAST) begin
                        state_nx = S_WAIT_LOCK;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nx = S_STABILIZE;
                        cnt_nx   = '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        attempt_fail = 1'b1;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                S_STABILIZE: begin
                    // Any dropout forfeits the whole stable run
                    if (!lock_s) begin
                        attempt_fail = 1'b1;
                    end else if (cnt == STABLE_LAST) begin
                        state_nx = S_RUN;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state_nx   = S_RESET_PLL;
                        cnt_nx     = '0;
                        retries_nx = 2'd0;
                        if (lock_losses != 8'hFF) begin
                            lock_losses_nx = lock_losses + 8'd1;
                        end
                    end
                end
                S_FAULT: begin
                    state_nx = S_FAULT;
                end
                default: begin
                    state_nx = S_RESET_PLL;
                    cnt_nx   = '0;
                end
            endcase

            // Failed attempt: retry or give up
            if (attempt_fail) begin
                cnt_nx = '0;
                if (retries == RETRY_LIMIT) begin
                    state_nx = S_FAULT;
                end else begin
                    state_nx   = S_RESET_PLL;
                    retries_nx = retries + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer (RST_CYCLES=4, LOCK_TIMEOUT=20,
// STABLE_CYCLES=8, MAX_RETRIES=2). The stimulus process pushes the expected
// output vector and the edge it must appear on; the monitor compares every
// output change against the head of that queue.
module tb_pll_reset_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       pll_lock = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic [1:0] retries;
    logic [7:0] lock_losses;

    typedef struct {
        int         at;
        logic [13:0] vec;
    } exp_t;

    exp_t        expq[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [13:0] cur;
    logic [13:0] prev = '0;
    exp_t        head;

    pll_reset_sequencer #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (2)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .pll_lock   (pll_lock),
        .restart    (restart),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .ready      (ready),
        .fault      (fault),
        .retries    (retries),
        .lock_losses(lock_losses)
    );

    always #5 clock = ~clock;

    // cyc is the number of rising edges seen so far
    always @(posedge clock) cyc <= cyc + 1;

    task automatic expect_out(input int at, input logic p, input logic s, input logic r,
                              input logic f, input int rt, input int ll);
        exp_t e;
        e.at  = at;
        e.vec = {p, s, r, f, 2'(rt), 8'(ll)};
        expq.push_back(e);
    endtask

    // Returns at the falling edge after rising edge e; inputs set there are
    // sampled on edge e+1.
    task automatic wait_until(input int e);
        while (cyc < e) @(negedge clock);
    endtask

    // Monitor: every output change must match the queue head at its edge
    always @(negedge clock) begin
        if (cyc >= 1) begin
            cur = {pll_rst, sys_rst_n, ready, fault, retries, lock_losses};
            while (expq.size() > 0 && expq[0].at < cyc) begin
                head = expq.pop_front();
                checks++;
                errors++;
                $display("FAIL missed@%0d: no output change seen, want pll_rst=%b sys_rst_n=%b ready=%b fault=%b retries=%0d lock_losses=%0d, got %b %b %b %b %0d %0d",
                         head.at, head.vec[13], head.vec[12], head.vec[11], head.vec[10],
                         head.vec[9:8], head.vec[7:0], cur[13], cur[12], cur[11], cur[10],
                         cur[9:8], cur[7:0]);
            end
            if (cyc == 1 || cur != prev) begin
                checks++;
                if (expq.size() > 0 && expq[0].at == cyc) begin
                    head = expq.pop_front();
                    if (cur !== head.vec) begin
                        errors++;
                        $display("FAIL out@%0d: got pll_rst=%b sys_rst_n=%b ready=%b fault=%b retries=%0d lock_losses=%0d, want %b %b %b %b %0d %0d",
                                 cyc, cur[13], cur[12], cur[11], cur[10], cur[9:8], cur[7:0],
                                 head.vec[13], head.vec[12], head.vec[11], head.vec[10],
                                 head.vec[9:8], head.vec[7:0]);
                    end
                end else begin
                    errors++;
                    $display("FAIL unexpected@%0d: got pll_rst=%b sys_rst_n=%b ready=%b fault=%b retries=%0d lock_losses=%0d",
                             cyc, cur[13], cur[12], cur[11], cur[10], cur[9:8], cur[7:0]);
                end
            end
            prev = cur;
        end
    end

    initial begin
        // Nominal bring-up: reset edges 1..3, pll_rst falls at 7,
        // lock first sampled at 12, release at 12+2+8
        expect_out(1,  1, 0, 0, 0, 0, 0);
        expect_out(7,  0, 0, 0, 0, 0, 0);
        expect_out(22, 0, 1, 1, 0, 0, 0);
        wait_until(3);  reset_n = 1'b1;
        wait_until(11); pll_lock = 1'b1;

        // Lock loss in RUN for 3 cycles: drop seen at 26, reset at 28
        wait_until(22);
        expect_out(28, 1, 0, 0, 0, 0, 1);
        expect_out(32, 0, 0, 0, 0, 0, 1);
        expect_out(41, 0, 1, 1, 0, 0, 1);
        wait_until(25); pll_lock = 1'b0;
        wait_until(28); pll_lock = 1'b1;

        // Never lock: three 4+20 attempts, then FAULT
        wait_until(41);
        expect_out(46,  1, 0, 0, 0, 0, 2);
        expect_out(50,  0, 0, 0, 0, 0, 2);
        expect_out(70,  1, 0, 0, 0, 1, 2);
        expect_out(74,  0, 0, 0, 0, 1, 2);
        expect_out(94,  1, 0, 0, 0, 2, 2);
        expect_out(98,  0, 0, 0, 0, 2, 2);
        expect_out(118, 1, 0, 0, 1, 2, 2);
        wait_until(43); pll_lock = 1'b0;

        // Restart from FAULT with lock present
        wait_until(125);
        expect_out(131, 1, 0, 0, 0, 0, 2);
        expect_out(135, 0, 0, 0, 0, 0, 2);
        expect_out(144, 0, 1, 1, 0, 0, 2);
        wait_until(130); restart = 1'b1; pll_lock = 1'b1;
        wait_until(131); restart = 1'b0;

        // Lock chatter: high 5, low 1, high; one retry then release
        wait_until(144);
        expect_out(149, 1, 0, 0, 0, 0, 3);
        expect_out(153, 0, 0, 0, 0, 0, 3);
        expect_out(163, 1, 0, 0, 0, 1, 3);
        expect_out(167, 0, 0, 0, 0, 1, 3);
        expect_out(176, 0, 1, 1, 0, 1, 3);
        wait_until(146); pll_lock = 1'b0;
        wait_until(155); pll_lock = 1'b1;
        wait_until(160); pll_lock = 1'b0;
        wait_until(161); pll_lock = 1'b1;

        // Restart on the edge STABILIZE would complete (194): no release
        wait_until(176);
        expect_out(181, 1, 0, 0, 0, 0, 4);
        expect_out(185, 0, 0, 0, 0, 0, 4);
        expect_out(194, 1, 0, 0, 0, 0, 4);
        expect_out(198, 0, 0, 0, 0, 0, 4);
        wait_until(178); pll_lock = 1'b0;
        wait_until(181); pll_lock = 1'b1;
        wait_until(193); restart = 1'b1;
        wait_until(194); restart = 1'b0;

        // Reset mid-STABILIZE: everything back to reset values, clean re-run
        expect_out(203, 1, 0, 0, 0, 0, 0);
        expect_out(207, 0, 0, 0, 0, 0, 0);
        expect_out(216, 0, 1, 1, 0, 0, 0);
        wait_until(202); reset_n = 1'b0;
        wait_until(203); reset_n = 1'b1;

        wait_until(226);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d expected events still pending, want 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
